// File: rtl/led_fade_pkg.sv
// Shared types and constants for the LED fade controller.
package led_fade_pkg;

    localparam int unsigned PWM_BITS = 8;
    localparam logic [PWM_BITS-1:0] DUTY_MAX = 8'd255;

    // Brightness FSM states
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } state_e;

endpackage

// File: rtl/led_fade_pwm_gen.sv
// 8-bit PWM generator: free-running period counter plus registered duty compare.
// wrap flags the last cycle of each period (counter at 255).
module pwm_gen
    import led_fade_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                wrap,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_q;

    // Counter advances every cycle; output is high while duty exceeds the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_q     <= (duty > pwm_cnt_q);
        end
    end

    assign wrap    = (pwm_cnt_q == DUTY_MAX);
    assign pwm_out = pwm_q;

endmodule

// File: rtl/led_fade.sv
// LED fade controller: synchronises the requested level, divides PWM wraps
// into step ticks, and ramps the PWM duty up or down one step per tick.
module led_fade
    import led_fade_pkg::*;
#(
    parameter int unsigned STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic led
);

    localparam logic [15:0] STEP_LAST = 16'(STEP_DIV - 1);

    logic                sync1_q;
    logic                lvl_s_q;
    logic [15:0]         step_cnt_q;
    logic [15:0]         step_cnt_d;
    logic                step_tick;
    logic                wrap;
    state_e              state_q;
    logic [PWM_BITS-1:0] duty_q;

    // Two-flop synchroniser for the asynchronous level request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            lvl_s_q <= 1'b0;
        end else begin
            sync1_q <= level_in;
            lvl_s_q <= sync1_q;
        end
    end

    // Step divider: every STEP_DIV-th PWM wrap produces a step tick
    always_comb begin
        step_cnt_d = step_cnt_q;
        step_tick  = 1'b0;
        if (wrap) begin
            if (step_cnt_q == STEP_LAST) begin
                step_cnt_d = '0;
                step_tick  = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + 1'b1;
            end
        end
    end

    // Step divider register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end

    // Brightness FSM; a direction reversal takes priority over a coincident step tick.
    // The >=/<= limit checks also cover reversals entered at full or zero duty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OFF;
            duty_q  <= '0;
        end else begin
            unique case (state_q)
                OFF: begin
                    duty_q <= '0;
                    if (lvl_s_q) state_q <= UP;
                end
                UP: begin
                    if (!lvl_s_q) begin
                        state_q <= DOWN;
                    end else if (step_tick) begin
                        if (duty_q >= DUTY_MAX - 1'b1) begin
                            duty_q  <= DUTY_MAX;
                            state_q <= ON;
                        end else begin
                            duty_q <= duty_q + 1'b1;
                        end
                    end
                end
                ON: begin
                    duty_q <= DUTY_MAX;
                    if (!lvl_s_q) state_q <= DOWN;
                end
                DOWN: begin
                    if (lvl_s_q) begin
                        state_q <= UP;
                    end else if (step_tick) begin
                        if (duty_q <= PWM_BITS'(1)) begin
                            duty_q  <= '0;
                            state_q <= OFF;
                        end else begin
                            duty_q <= duty_q - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    pwm_gen u_pwm (
        .clk     (clk),
        .rst     (rst),
        .duty    (duty_q),
        .wrap    (wrap),
        .pwm_out (led)
    );

endmodule

// File: tb/tb_led_fade.sv
// Bench for led_fade. Three instances run concurrently:
//   u_a (STEP_DIV=1): reset, latency, simultaneous reversal, reversal, mid-ramp reset
//   u_r (STEP_DIV=1): full ramp and saturation, per-period high-count scoreboard
//   u_b (STEP_DIV=2): table of level/edge/expected-state vectors
// Edge k means the k-th rising clock edge after reset release; with STEP_DIV=1
// step ticks land on edges 256*m, with STEP_DIV=2 on edges 512*m.
module tb_led_fade;
    import led_fade_pkg::*;

    typedef struct {
        logic   lvl;
        int     edge_no;
        state_e st;
        int     duty;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_r = 1'b1;
    logic rst_b = 1'b1;
    logic lvl_a = 1'b0;
    logic lvl_r = 1'b0;
    logic lvl_b = 1'b0;
    logic led_a;
    logic led_r;
    logic led_b;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];
    vec_t tbl[18];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_fade #(.STEP_DIV(1)) u_a (.clk(clk), .rst(rst_a), .level_in(lvl_a), .led(led_a));
    led_fade #(.STEP_DIV(1)) u_r (.clk(clk), .rst(rst_r), .level_in(lvl_r), .led(led_r));
    led_fade #(.STEP_DIV(2)) u_b (.clk(clk), .rst(rst_b), .level_in(lvl_b), .led(led_b));

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge following edge k after base
    task automatic wait_k(input int base, input int k);
        while (cyc - base < k) @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input state_e st, input int duty);
        check({tag, " state"}, int'(u_a.state_q), int'(st));
        check({tag, " duty"}, int'(u_a.duty_q), duty);
    endtask

    task automatic run_a();
        int base;
        #1;
        rst_a = 1'b0;
        lvl_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a_reset led", int'(led_a), 0);
            check("a_reset state", int'(u_a.state_q), int'(OFF));
        end
        rst_a = 1'b1;
        base  = cyc;
        wait_k(base, 2);     chk_a("a_release k2", OFF, 0);
        wait_k(base, 3);     chk_a("a_release k3", UP, 0);
        // Reversal reaches the FSM exactly on the tick edge 13056 (duty 50)
        wait_k(base, 13053); lvl_a = 1'b0;
        wait_k(base, 13055); chk_a("a_simul before", UP, 50);
        wait_k(base, 13056); chk_a("a_simul tick", DOWN, 50);
        lvl_a = 1'b1;
        wait_k(base, 13058); chk_a("a_back k2", DOWN, 50);
        wait_k(base, 13059); chk_a("a_back k3", UP, 50);
        wait_k(base, 13312); chk_a("a_resume", UP, 51);
        wait_k(base, 25856); chk_a("a_at100", UP, 100);
        lvl_a = 1'b0;
        wait_k(base, 25858); chk_a("a_rev k2", UP, 100);
        wait_k(base, 25859); chk_a("a_rev k3", DOWN, 100);
        wait_k(base, 26111); chk_a("a_rev pretick", DOWN, 100);
        wait_k(base, 26112); chk_a("a_rev tick", DOWN, 99);
        lvl_a = 1'b1;
        wait_k(base, 26115); chk_a("a_reup", UP, 99);
        wait_k(base, 33536); chk_a("a_at128", UP, 128);
        wait_k(base, 33540);
        check("a_at128 led", int'(led_a), 1);
        rst_a = 1'b0;
        #1;
        chk_a("a_midreset", OFF, 0);
        check("a_midreset led", int'(led_a), 0);
        @(negedge clk);
        chk_a("a_midreset held", OFF, 0);
        rst_a = 1'b1;
        base  = cyc;
        wait_k(base, 3);     chk_a("a_restart k3", UP, 0);
        wait_k(base, 255);   chk_a("a_restart k255", UP, 0);
        wait_k(base, 256);   chk_a("a_restart k256", UP, 1);
    endtask

    task automatic run_r();
        int highs;
        int exp_cnt;
        int exp_duty;
        #1;
        rst_r = 1'b0;
        lvl_r = 1'b1;
        repeat (2) @(negedge clk);
        check("r_reset duty", int'(u_r.duty_q), 0);
        rst_r = 1'b1;
        // Period m covers samples after edges 256m+1..256m+256 and runs at duty min(m,255)
        for (int m = 0; m < 264; m++) begin
            exp_q.push_back((m < 255) ? m : 255);
            highs = 0;
            for (int j = 0; j < 256; j++) begin
                @(negedge clk);
                if (led_r) highs++;
            end
            exp_cnt  = exp_q.pop_front();
            exp_duty = (m + 1 < 255) ? m + 1 : 255;
            check($sformatf("r_highs p%0d", m), highs, exp_cnt);
            check($sformatf("r_duty p%0d", m), int'(u_r.duty_q), exp_duty);
            check($sformatf("r_state p%0d", m), int'(u_r.state_q),
                  (exp_duty < 255) ? int'(UP) : int'(ON));
        end
    endtask

    task automatic run_b();
        int base;
        tbl[0]  = '{1'b1, 2,    OFF,  0};
        tbl[1]  = '{1'b1, 3,    UP,   0};
        tbl[2]  = '{1'b1, 511,  UP,   0};
        tbl[3]  = '{1'b1, 512,  UP,   1};
        tbl[4]  = '{1'b1, 1023, UP,   1};
        tbl[5]  = '{1'b1, 1024, UP,   2};
        tbl[6]  = '{1'b1, 2560, UP,   5};
        tbl[7]  = '{1'b0, 2562, UP,   5};
        tbl[8]  = '{1'b0, 2563, DOWN, 5};
        tbl[9]  = '{1'b0, 3071, DOWN, 5};
        tbl[10] = '{1'b0, 3072, DOWN, 4};
        tbl[11] = '{1'b0, 5119, DOWN, 1};
        tbl[12] = '{1'b0, 5120, OFF,  0};
        tbl[13] = '{1'b0, 5632, OFF,  0};
        tbl[14] = '{1'b1, 5634, OFF,  0};
        tbl[15] = '{1'b1, 5635, UP,   0};
        tbl[16] = '{1'b1, 6143, UP,   0};
        tbl[17] = '{1'b1, 6144, UP,   1};
        #1;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        check("b_reset led", int'(led_b), 0);
        rst_b = 1'b1;
        base  = cyc;
        for (int i = 0; i < 18; i++) begin
            lvl_b = tbl[i].lvl;
            wait_k(base, tbl[i].edge_no);
            check($sformatf("b_vec%0d state", i), int'(u_b.state_q), int'(tbl[i].st));
            check($sformatf("b_vec%0d duty", i), int'(u_b.duty_q), tbl[i].duty);
        end
    endtask

    initial begin
        fork
            begin run_a(); end
            begin run_r(); end
            begin run_b(); end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no completion, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
